// File: rtl/unary_bin_decoder_pkg.sv
// Shared definitions for the unary-to-binary window decoder.
package unary_bin_decoder_pkg;

  localparam int unsigned DEFAULT_BITWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/unary_bin_decoder_if.sv
// Stream-in / result-out port bundle of the unary-to-binary decoder.
interface unary_bin_decoder_if
  import unary_bin_decoder_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH
);

  logic              iStart;
  logic              iEn;
  logic              iA;
  logic              iReady;
  logic              oValid;
  logic [BITWIDTH:0] oData;
  logic              oBusy;

  modport master (
    output iStart, iEn, iA, iReady,
    input  oValid, oData, oBusy
  );

  modport slave (
    input  iStart, iEn, iA, iReady,
    output oValid, oData, oBusy
  );

endinterface

// File: rtl/ones_window_counter.sv
// Sample counter and ones accumulator for one 2^BITWIDTH-sample window.
module ones_window_counter #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClear,
  input  logic              iEn,
  input  logic              iA,
  output logic              oLast,
  output logic [BITWIDTH:0] oNext
);

  localparam logic [BITWIDTH-1:0] CntOne = {{(BITWIDTH-1){1'b0}}, 1'b1};

  logic [BITWIDTH-1:0] cnt;
  logic [BITWIDTH:0]   acc;

  assign oLast = iEn && (&cnt);
  assign oNext = acc + {{BITWIDTH{1'b0}}, iA};

  // Counter wraps to 0 naturally on the last sample.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
      acc <= '0;
    end else if (iClear) begin
      cnt <= '0;
      acc <= '0;
    end else if (iEn) begin
      cnt <= cnt + CntOne;
      acc <= oNext;
    end
  end

endmodule

// File: rtl/unary_bin_decoder.sv
// Counts ones over a 2^BITWIDTH-sample window and hands the count out on valid/ready.
module unary_bin_decoder
  import unary_bin_decoder_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH
) (
  input logic               iClk,
  input logic               iRst,
  unary_bin_decoder_if.slave bus
);

  state_e            state;
  logic              last;
  logic [BITWIDTH:0] next_count;

  // Counter is held clear outside RUN so every window starts from zero.
  ones_window_counter #(
    .BITWIDTH(BITWIDTH)
  ) u_counter (
    .iClk  (iClk),
    .iRst  (iRst),
    .iClear(state != RUN),
    .iEn   ((state == RUN) && bus.iEn),
    .iA    (bus.iA),
    .oLast (last),
    .oNext (next_count)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      bus.oValid <= 1'b0;
      bus.oData  <= '0;
      bus.oBusy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.iStart) begin
            state     <= RUN;
            bus.oBusy <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            state      <= DONE;
            bus.oData  <= next_count;
            bus.oValid <= 1'b1;
            bus.oBusy  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.iReady) begin
            bus.oValid <= 1'b0;
            if (bus.iStart) begin
              state     <= RUN;
              bus.oBusy <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          bus.oValid <= 1'b0;
          bus.oBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
